ram_responder: RTL and testbench

//  Backing-store responder for the cache-to-RAM request interface.

---
 rtl/ram_responder_pkg.sv | 18 +
 rtl/ram_responder_if.sv | 21 ++
 rtl/ram_responder_array.sv | 25 ++
 rtl/ram_responder.sv | 121 ++++++++++++
 tb/tb_ram_responder.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/ram_responder_pkg.sv
// Shared types and default sizing for the RAM responder (slow main-memory model).
package ram_responder_pkg;

    localparam int WORD_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int DEPTH     = 1024;
    localparam int ADDR_BITS = 10;
    localparam int LATENCY   = 4;
    localparam int CNT_W     = 16;
    localparam int LAT_CNT_W = 8;

    // IDLE: response high, last request complete. BUSY: request in flight.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/ram_responder_if.sv
// Cache-to-RAM request interface.
//
// Handshake: there is no valid strobe. The master starts a request by changing
// at least one of {data, addr, wr} and must then hold them stable. The slave
// drops response on the next clock edge and raises it again once the request
// completes; out carries read data while response is high. Presenting the same
// {data, addr, wr} twice in a row is indistinguishable from holding, so it does
// not issue a second request.
interface ram_responder_if;
    import ram_responder_pkg::*;

    logic [WORD_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic              response;
    logic [WORD_W-1:0] out;

    modport master (output data, addr, wr, input response, out);
    modport slave  (input data, addr, wr, output response, out);

endinterface

// File: rtl/ram_responder_array.sv
// Synchronous single-port word memory with a registered read port.
// Contents are not touched by reset.
module ram_array #(
    parameter int DEPTH     = 1024,
    parameter int ADDR_BITS = 10,
    parameter int WORD_W    = 32
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_idx,
    input  logic [WORD_W-1:0]    i_wdata,
    output logic [WORD_W-1:0]    o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    // Write when enabled; always register the word at the current index.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
        o_rdata <= r_mem[i_idx];
    end

endmodule

// File: rtl/ram_responder.sv
// Backing-store responder: detects a new request as any change on the request
// inputs, waits a fixed latency, then commits the write or returns read data.
// Also counts completed reads and writes (saturating).
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int DEPTH     = ram_responder_pkg::DEPTH,
    parameter int ADDR_BITS = ram_responder_pkg::ADDR_BITS,
    parameter int LATENCY   = ram_responder_pkg::LATENCY,
    parameter int CNT_W     = ram_responder_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    ram_responder_if.slave   bus,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count,
    output state_t           o_dbg_state
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LATENCY - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [WORD_W-1:0]      r_data_q;
    logic [ADDR_W-1:0]      r_addr_q;
    logic                   r_wr_q;
    logic [LAT_CNT_W-1:0]   r_cnt;
    logic                   r_response;
    logic [WORD_W-1:0]      r_out;
    logic [CNT_W-1:0]       r_rd_count;
    logic [CNT_W-1:0]       r_wr_count;

    logic                   w_req;
    logic                   w_done;
    logic                   w_we;
    logic [ADDR_BITS-1:0]   w_idx;
    logic [WORD_W-1:0]      w_rdata;

    // A request is any difference between the live inputs and the latched copy.
    assign w_req  = ({bus.data, bus.addr, bus.wr} != {r_data_q, r_addr_q, r_wr_q});
    assign w_done = (r_state == BUSY) && !w_req && (r_cnt == '0);
    assign w_we   = w_done && r_wr_q;

    // Point the array at the incoming address on the detect edge so the read
    // word is already registered by completion, even with a latency of one.
    assign w_idx  = w_req ? bus.addr[ADDR_BITS-1:0] : r_addr_q[ADDR_BITS-1:0];

    ram_array #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS),
        .WORD_W    (WORD_W)
    ) u_array (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_idx   (w_idx),
        .i_wdata (r_data_q),
        .o_rdata (w_rdata)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: any input change (re)starts BUSY; count expiry returns to IDLE.
    always_comb begin
        w_next_state = r_state;
        if (w_req) begin
            w_next_state = BUSY;
        end else if (w_done) begin
            w_next_state = IDLE;
        end
    end

    // Request latch, latency countdown, response/read data and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_q   <= '0;
            r_addr_q   <= '0;
            r_wr_q     <= 1'b0;
            r_cnt      <= '0;
            r_response <= 1'b1;
            r_out      <= '0;
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (w_req) begin
            r_data_q   <= bus.data;
            r_addr_q   <= bus.addr;
            r_wr_q     <= bus.wr;
            r_cnt      <= LAT_LOAD;
            r_response <= 1'b0;
        end else if (r_state == BUSY) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end else begin
                r_response <= 1'b1;
                if (r_wr_q) begin
                    if (r_wr_count != '1) begin
                        r_wr_count <= r_wr_count + 1'b1;
                    end
                end else begin
                    r_out <= w_rdata;
                    if (r_rd_count != '1) begin
                        r_rd_count <= r_rd_count + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.response = r_response;
    assign bus.out      = r_out;
    assign rd_count     = r_rd_count;
    assign wr_count     = r_wr_count;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_ram_responder.sv
// Testbench for ram_responder: directed requests, expected responses queued at
// issue time and compared by a monitor whenever response rises.
module tb_ram_responder;
    import ram_responder_pkg::*;

    localparam int LAT   = 4;
    localparam int EXP_W = 72;  // {out[31:0], rd[15:0], wr[15:0], busy_cycles[7:0]}

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_responder_if u_if ();
    ram_responder_if s_if ();

    logic [15:0] rd_count;
    logic [15:0] wr_count;
    state_t      dbg_state;
    logic [3:0]  s_rd_count;
    logic [3:0]  s_wr_count;
    state_t      s_dbg_state;

    ram_responder #(.LATENCY(LAT)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (u_if.slave),
        .rd_count    (rd_count),
        .wr_count    (wr_count),
        .o_dbg_state (dbg_state)
    );

    // Narrow-counter instance so saturation is reachable in a short run.
    ram_responder #(.LATENCY(1), .CNT_W(4)) u_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (s_if.slave),
        .rd_count    (s_rd_count),
        .wr_count    (s_wr_count),
        .o_dbg_state (s_dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int                checks = 0;
    int                errors = 0;
    logic [EXP_W-1:0]  exp_q[$];
    logic [31:0]       m_mem [1024];
    int                m_rd;
    int                m_wr;
    logic [31:0]       m_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
        u_if.wr   = w;
        u_if.addr = a;
        u_if.data = d;
    endtask

    // Reference model: a completed request updates memory, out and counters.
    task automatic model_req(input logic w, input logic [31:0] a, input logic [31:0] d, input int busy);
        if (w) begin
            m_mem[a[9:0]] = d;
            if (m_wr < 16'hFFFF) m_wr++;
        end else begin
            m_out = m_mem[a[9:0]];
            if (m_rd < 16'hFFFF) m_rd++;
        end
        exp_q.push_back({m_out, 16'(m_rd), 16'(m_wr), 8'(busy)});
    endtask

    task automatic wait_done(input string name);
        int n;
        @(negedge clk);
        check({name, "_busy"}, {31'd0, u_if.response}, 32'd0);
        n = 0;
        while (u_if.response !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: response got 0 expected 1", name);
        end
    endtask

    task automatic issue(input string name, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        drive(w, a, d);
        model_req(w, a, d, LAT);
        wait_done(name);
    endtask

    // ---------------- monitor ----------------
    logic prev_resp = 1'b1;
    int   busy_cyc  = 0;

    always @(negedge clk) begin
        logic [EXP_W-1:0] ex;
        if (!rst_n) begin
            prev_resp = 1'b1;
            busy_cyc  = 0;
        end else begin
            if (u_if.response !== 1'b1) begin
                busy_cyc++;
            end else if (!prev_resp) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_response: got completion expected none");
                end else begin
                    ex = exp_q.pop_front();
                    check("mon_out",      u_if.out,            ex[71:40]);
                    check("mon_rd_count", {16'd0, rd_count},   {16'd0, ex[39:24]});
                    check("mon_wr_count", {16'd0, wr_count},   {16'd0, ex[23:8]});
                    check("mon_latency",  32'(busy_cyc),       {24'd0, ex[7:0]});
                end
                busy_cyc = 0;
            end
            prev_resp = u_if.response;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        foreach (m_mem[i]) m_mem[i] = 32'd0;
        m_rd  = 0;
        m_wr  = 0;
        m_out = 32'd0;
        drive(1'b0, 32'd0, 32'd0);
        s_if.wr   = 1'b0;
        s_if.addr = 32'd0;
        s_if.data = 32'd0;

        repeat (3) @(negedge clk);
        check("rst_response", {31'd0, u_if.response}, 32'd1);
        rst_n = 1'b1;

        // Idle after reset: zero inputs never form a request.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_response", {31'd0, u_if.response}, 32'd1);
        end
        check("idle_out",      u_if.out,          32'd0);
        check("idle_rd_count", {16'd0, rd_count}, 32'd0);
        check("idle_wr_count", {16'd0, wr_count}, 32'd0);
        check("idle_state",    {31'd0, dbg_state}, {31'd0, IDLE});

        // Write then read back.
        issue("wr5", 1'b1, 32'd5, 32'hDEADBEEF);
        issue("rd5", 1'b0, 32'd5, 32'd0);

        // Upper address bits alias onto the same word.
        issue("wr405", 1'b1, 32'h405, 32'h1234);
        issue("rd5_alias", 1'b0, 32'd5, 32'd0);

        // Restart: read 7 is abandoned two cycles in, replaced by read 9.
        issue("wr9", 1'b1, 32'd9, 32'h9999_0009);
        @(negedge clk);
        drive(1'b0, 32'd7, 32'd0);
        @(negedge clk);
        check("restart_state", {31'd0, dbg_state}, {31'd0, BUSY});
        @(negedge clk);
        drive(1'b0, 32'd9, 32'd0);
        model_req(1'b0, 32'd9, 32'd0, LAT + 2);
        wait_done("restart");

        // Reset in the middle of a write to word 3.
        issue("wr3", 1'b1, 32'd3, 32'h55);
        @(negedge clk);
        drive(1'b1, 32'd3, 32'hAA);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_response", {31'd0, u_if.response}, 32'd1);
        check("midrst_out",      u_if.out,          32'd0);
        check("midrst_rd_count", {16'd0, rd_count}, 32'd0);
        check("midrst_wr_count", {16'd0, wr_count}, 32'd0);
        check("midrst_state",    {31'd0, dbg_state}, {31'd0, IDLE});
        drive(1'b0, 32'd0, 32'd0);
        m_rd  = 0;
        m_wr  = 0;
        m_out = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue("rd3_after_rst", 1'b0, 32'd3, 32'd0);

        // Saturation on the narrow-counter instance.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            s_if.addr = (i % 2 == 0) ? 32'd1 : 32'd2;
            repeat (2) @(negedge clk);
            if (i == 14) check("sat_reach", {28'd0, s_rd_count}, 32'hF);
        end
        check("sat_hold",     {28'd0, s_rd_count}, 32'hF);
        check("sat_wr_count", {28'd0, s_wr_count}, 32'd0);

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
